ides_word_align_ctrl: RTL

Word-alignment controller for the IDES8 deserializer lanes, run after the delay-tap calibrator reports success. It watches the 8-bit word from the forwarded-clock lane and pulses the shared `calib` (bit-slip) input of both deserializers until that word equals the expected clock pattern. It then declares lock, monitors for loss of lock, and requests a delay recalibration when no slip position matches.

---
 rtl/ides_word_align_ctrl_pkg.sv | 23 ++
 rtl/ides_word_align_ctrl_run_cnt.sv | 31 +++
 rtl/ides_word_align_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ides_word_align_ctrl_pkg.sv
// Shared definitions for the IDES8 word-alignment controller: state encodings,
// default clock-lane pattern and counter widths.
package ides_word_align_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SLIP   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } align_state_e;

    localparam logic [7:0] DEFAULT_PATTERN = 8'hF0;
    localparam int         RUN_W           = 8;
    localparam int         SLIP_W          = 4;
    localparam int         WAIT_W          = 4;

    function automatic logic [RUN_W-1:0] sat_inc8(input logic [RUN_W-1:0] v);
        return (v == {RUN_W{1'b1}}) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ides_word_align_ctrl_run_cnt.sv
// Saturating consecutive-event counter; hit flags the event that reaches thresh.
module align_run_cnt
    import ides_word_align_ctrl_pkg::*;
(
    input  logic             clk_sys,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             inc,
    input  logic [RUN_W-1:0] thresh,
    output logic             hit
);

    logic [RUN_W-1:0] cnt;
    logic [RUN_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = sat_inc8(cnt);
        hit     = inc && !clr && (cnt_nxt >= thresh);
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/ides_word_align_ctrl.sv
// Bit-slip word aligner for the IDES8 lanes: slips until the clock lane shows
// PATTERN, holds lock, and requests delay recalibration if no position matches.
//
//  state  | meaning
//  IDLE   | delay calibration not done, everything held clear
//  CHECK  | comparing clock-lane word, counting consecutive matches
//  SLIP   | one-cycle calib pulse, slip counter advanced
//  WAIT   | deserializer settling after a slip, compares ignored
//  LOCKED | aligned, counting consecutive misses
//  FAIL   | all slip positions exhausted, waiting for cal drop or realign
module ides_word_align_ctrl
    import ides_word_align_ctrl_pkg::*;
#(
    parameter logic [7:0] PATTERN    = DEFAULT_PATTERN,
    parameter int         CALIB_WAIT = 4,
    parameter int         LOCK_CNT   = 16,
    parameter int         LOSS_CNT   = 4,
    parameter int         MAX_SLIP   = 8
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              cal,
    input  logic              realign,
    input  logic [7:0]        q_ck,
    output logic              calib,
    output logic              aligned,
    output logic              align_err,
    output logic              recal_req,
    output logic [SLIP_W-1:0] slip_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_LD  = 4'(CALIB_WAIT);
    localparam logic [RUN_W-1:0]  LOCK_TH  = 8'(LOCK_CNT);
    localparam logic [RUN_W-1:0]  LOSS_TH  = 8'(LOSS_CNT);
    localparam logic [SLIP_W-1:0] SLIP_MAX = 4'(MAX_SLIP);

    align_state_e      state;
    logic [WAIT_W-1:0] wait_cnt;

    logic q_match;
    logic chk_run;
    logic lk_run;
    logic match_inc, match_clr, match_hit;
    logic miss_inc, miss_clr, miss_hit;

    always_comb begin
        q_match   = (q_ck == PATTERN);
        chk_run   = cal && !realign && (state == ST_CHECK);
        lk_run    = cal && !realign && (state == ST_LOCKED);
        match_inc = chk_run && q_match;
        match_clr = !match_inc;
        miss_inc  = lk_run && !q_match;
        miss_clr  = !miss_inc;
    end

    align_run_cnt u_match_cnt (
        .clk_sys (pclk),
        .rst_b   (rst),
        .clr     (match_clr),
        .inc     (match_inc),
        .thresh  (LOCK_TH),
        .hit     (match_hit)
    );

    align_run_cnt u_miss_cnt (
        .clk_sys (pclk),
        .rst_b   (rst),
        .clr     (miss_clr),
        .inc     (miss_inc),
        .thresh  (LOSS_TH),
        .hit     (miss_hit)
    );

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            calib     <= 1'b0;
            aligned   <= 1'b0;
            align_err <= 1'b0;
            recal_req <= 1'b0;
            slip_cnt  <= '0;
            wait_cnt  <= '0;
        end else begin
            calib     <= 1'b0;
            recal_req <= 1'b0;
            if (!cal) begin
                state     <= ST_IDLE;
                aligned   <= 1'b0;
                align_err <= 1'b0;
                slip_cnt  <= '0;
                wait_cnt  <= '0;
            end else if (realign) begin
                state     <= ST_CHECK;
                aligned   <= 1'b0;
                align_err <= 1'b0;
                slip_cnt  <= '0;
                wait_cnt  <= '0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_CHECK;
                    ST_CHECK: begin
                        if (q_match) begin
                            if (match_hit) begin
                                state   <= ST_LOCKED;
                                aligned <= 1'b1;
                            end
                        end else if (slip_cnt >= SLIP_MAX) begin
                            state     <= ST_FAIL;
                            align_err <= 1'b1;
                            recal_req <= 1'b1;
                        end else begin
                            state    <= ST_SLIP;
                            calib    <= 1'b1;
                            slip_cnt <= slip_cnt + 4'd1;
                            wait_cnt <= WAIT_LD;
                        end
                    end
                    // The wait count spans the slip cycle itself, so the next
                    // compare lands CALIB_WAIT edges after calib falls.
                    ST_SLIP, ST_WAIT: begin
                        wait_cnt <= wait_cnt - 4'd1;
                        state    <= (wait_cnt <= 4'd1) ? ST_CHECK : ST_WAIT;
                    end
                    ST_LOCKED: begin
                        if (miss_hit) begin
                            state    <= ST_CHECK;
                            aligned  <= 1'b0;
                            slip_cnt <= '0;
                        end
                    end
                    ST_FAIL: state <= ST_FAIL;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
